ts_fifo_pop_arb: RTL and testbench
==================================

TS_FIFO_POP_ARB -- requirements
Module: ts_fifo_pop_arb

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of pop requesters (2..4).
REQ-002 SHALL have parameter RD_LAT, default 1, FIFO read latency in cycles from pop to data (1..3).
REQ-003 SHALL have port CLK_CORE, input, 1, the single core clock.
REQ-004 SHALL have port RST_CORE, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port REQ_VALID, input, NREQ, per-requester pop request (level), held until granted.
REQ-006 SHALL have port REQ_GNT, output, NREQ, one-hot grant pulse.
REQ-007 SHALL have port RSP_VALID, output, NREQ, one-cycle response strobe to the granted requester.
REQ-008 SHALL have port RSP_TS, output, 76, returned timestamp_bus word.
REQ-009 SHALL have port TS_FIFO_POP, output, 1, pop strobe to timestamp_fifo.
REQ-010 SHALL have port TS_FIFO_RD, input, 76, FIFO read data.
REQ-011 SHALL have port TS_FIFO_WORDS, input, 5, FIFO occupancy.
REQ-012 SHALL have port FLUSH_REQ, input, 1, drain-FIFO request pulse.
REQ-013 SHALL have port FLUSH_DONE, output, 1, one-cycle drain-complete pulse.
REQ-014 SHALL have port REG_TSARB_STARVE_CNT, output, 16, saturating starvation count.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, FLUSH_POP, FLUSH_GAP.
REQ-016 IDLE: FLUSH_REQ SHALL take priority and go to FLUSH_POP; else any REQ_VALID with TS_FIFO_WORDS!=0 SHALL go to ISSUE, latching the round-robin winner.
REQ-017 ISSUE SHALL last exactly one cycle, with TS_FIFO_POP=1 and REQ_GNT[winner]=1, then go to WAIT.
REQ-018 WAIT SHALL count RD_LAT cycles; on the last one, RSP_TS SHALL capture TS_FIFO_RD and RSP_VALID[winner] SHALL pulse on the next cycle, and the FSM SHALL return to IDLE.
REQ-019 Throughput: at most one pop per RD_LAT+2 cycles; a pop SHALL never be issued while a pop is in flight.
REQ-020 RSP_TS SHALL hold its last value until the next capture.
REQ-021 Round-robin: the priority pointer SHALL advance to winner+1 (mod NREQ) when RSP_VALID fires; with only one requester active, that requester SHALL win every time.
REQ-022 Requests with TS_FIFO_WORDS==0 SHALL stay pending: no pop, no grant.
REQ-023 REG_TSARB_STARVE_CNT SHALL increment each cycle that (|REQ_VALID && TS_FIFO_WORDS==0 && state==IDLE), and SHALL saturate at 16'hFFFF.
REQ-024 FLUSH_POP: if TS_FIFO_WORDS!=0, SHALL assert TS_FIFO_POP for one cycle and go to FLUSH_GAP; if TS_FIFO_WORDS==0, SHALL pulse FLUSH_DONE and go to IDLE.
REQ-025 FLUSH_GAP SHALL last RD_LAT cycles with no pop, then return to FLUSH_POP.
REQ-026 No REQ_GNT and no RSP_VALID SHALL occur during flush; pending requests SHALL be serviced after FLUSH_DONE.
REQ-027 FLUSH_REQ arriving in ISSUE or WAIT SHALL be latched and taken in IDLE after the in-flight response completes.
REQ-028 REQ_VALID dropping after ISSUE SHALL NOT cancel the response.

Reset
REQ-029 On RST_CORE: state=IDLE, pointer=0, latched flush=0; REQ_GNT, RSP_VALID, TS_FIFO_POP, FLUSH_DONE and REG_TSARB_STARVE_CNT SHALL be 0, and RSP_TS SHALL be 76'h0.
REQ-030 Reset mid-WAIT SHALL discard the in-flight response; the FIFO pop is not replayed.

Structure
REQ-031 timestamp_bus and the FSM enum ts_arb_state_e SHALL live in common_cfg.
REQ-032 Round-robin selection SHALL be the sub-module ts_rr_arb (inputs NREQ request bits and pointer; output one-hot winner).

Verification
REQ-033 Single request: REQ_VALID=2'b01, WORDS=3, TS_FIFO_RD=76'hA5 -> POP and GNT=01 at t, RSP_VALID=01 with RSP_TS=76'hA5 at t+2 (RD_LAT=1).
REQ-034 Contention: REQ_VALID=2'b11 held, WORDS=8 -> grants alternate 01,10,01,10, spaced 3 cycles apart.
REQ-035 Empty FIFO: REQ_VALID=01, WORDS=0 for 10 cycles -> no POP, STARVE_CNT=10; WORDS=1 -> grant issued.
REQ-036 Flush: WORDS=4, FLUSH_REQ pulsed, WORDS decremented 1 cycle after each pop -> exactly 4 POPs, then FLUSH_DONE, no grants in between.
REQ-037 Flush during WAIT: response completes first, then flush begins; STARVE_CNT preloaded near 16'hFFFF saturates at FFFF.
REQ-038 RST_CORE asserted in WAIT -> no RSP_VALID, all outputs 0, FSM in IDLE.

Source files
------------

// File: rtl/common_cfg.sv
// Shared types for the timestamp FIFO pop arbiter.
package common_cfg;

    localparam int TS_W = 76;

    typedef logic [TS_W-1:0] timestamp_bus;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT      = 3'd2,
        FLUSH_POP = 3'd3,
        FLUSH_GAP = 3'd4
    } ts_arb_state_e;

endpackage

// File: rtl/ts_rr_arb.sv
// Round-robin pick: lowest set request at or above the pointer, wrapping.
module ts_rr_arb #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    logic [NREQ-1:0] rot;
    logic [NREQ-1:0] pick;

    // Rotate so the pointer sits at bit 0, isolate lowest set bit, rotate back.
    always_comb begin
        rot  = NREQ'({req, req} >> ptr);
        pick = rot & (~rot + NREQ'(1));
        gnt  = NREQ'(({pick, pick} << ptr) >> NREQ);
    end

endmodule

// File: rtl/ts_fifo_pop_arb.sv
// Arbitrates timestamp FIFO pops between requesters and drains on flush.
module ts_fifo_pop_arb
    import common_cfg::*;
#(
    parameter int NREQ   = 2,
    parameter int RD_LAT = 1
) (
    input  logic               CLK_CORE,
    input  logic               RST_CORE,
    input  logic [NREQ-1:0]    REQ_VALID,
    output logic [NREQ-1:0]    REQ_GNT,
    output logic [NREQ-1:0]    RSP_VALID,
    output timestamp_bus       RSP_TS,
    output logic               TS_FIFO_POP,
    input  timestamp_bus       TS_FIFO_RD,
    input  logic [4:0]         TS_FIFO_WORDS,
    input  logic               FLUSH_REQ,
    output logic               FLUSH_DONE,
    output logic [15:0]        REG_TSARB_STARVE_CNT
);

    localparam int         PW   = (NREQ > 2) ? 2 : 1;
    localparam logic [1:0] LAST = 2'(RD_LAT - 1);

    ts_arb_state_e   state;
    logic [NREQ-1:0] win_q;
    logic [NREQ-1:0] rr_win;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   ptr_nx;
    logic [1:0]      cnt_q;
    logic            flush_pend;
    logic [NREQ-1:0] rsp_valid_q;
    timestamp_bus    rsp_ts_q;
    logic [15:0]     starve_q;
    logic            words_nz;
    logic            any_req;

    assign words_nz = |TS_FIFO_WORDS;
    assign any_req  = |REQ_VALID;

    ts_rr_arb #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req (REQ_VALID),
        .ptr (ptr_q),
        .gnt (rr_win)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_q[i]) win_idx = PW'(i);
        end
        ptr_nx = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
    end

    always_ff @(posedge CLK_CORE or posedge RST_CORE) begin
        if (RST_CORE) begin
            state       <= IDLE;
            win_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            flush_pend  <= 1'b0;
            rsp_valid_q <= '0;
            rsp_ts_q    <= '0;
            starve_q    <= '0;
        end else begin
            rsp_valid_q <= '0;
            if (state == IDLE && any_req && !words_nz && starve_q != 16'hFFFF)
                starve_q <= starve_q + 16'd1;
            unique case (state)
                IDLE: begin
                    if (FLUSH_REQ || flush_pend) begin
                        flush_pend <= 1'b0;
                        state      <= FLUSH_POP;
                    end else if (any_req && words_nz) begin
                        win_q <= rr_win;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (FLUSH_REQ) flush_pend <= 1'b1;
                    cnt_q <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (FLUSH_REQ) flush_pend <= 1'b1;
                    if (cnt_q == LAST) begin
                        rsp_ts_q    <= TS_FIFO_RD;
                        rsp_valid_q <= win_q;
                        ptr_q       <= ptr_nx;
                        state       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                FLUSH_POP: begin
                    cnt_q <= '0;
                    state <= words_nz ? FLUSH_GAP : IDLE;
                end
                FLUSH_GAP: begin
                    if (cnt_q == LAST) state <= FLUSH_POP;
                    else cnt_q <= cnt_q + 2'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign TS_FIFO_POP = (state == ISSUE) || (state == FLUSH_POP && words_nz);
    assign REQ_GNT     = (state == ISSUE) ? win_q : '0;
    assign FLUSH_DONE  = (state == FLUSH_POP) && !words_nz;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_TS      = rsp_ts_q;
    assign REG_TSARB_STARVE_CNT = starve_q;

endmodule

// File: tb/tb_ts_fifo_pop_arb.sv
// Directed self-checking bench for ts_fifo_pop_arb (NREQ=2, RD_LAT=1).
module tb_ts_fifo_pop_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [1:0]  rsp_valid;
    logic [75:0] rsp_ts;
    logic        pop;
    logic [75:0] rd;
    logic [4:0]  words;
    logic        flush_req;
    logic        flush_done;
    logic [15:0] starve;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ts_fifo_pop_arb #(
        .NREQ   (2),
        .RD_LAT (1)
    ) dut (
        .CLK_CORE             (clk),
        .RST_CORE             (rst),
        .REQ_VALID            (req),
        .REQ_GNT              (gnt),
        .RSP_VALID            (rsp_valid),
        .RSP_TS               (rsp_ts),
        .TS_FIFO_POP          (pop),
        .TS_FIFO_RD           (rd),
        .TS_FIFO_WORDS        (words),
        .FLUSH_REQ            (flush_req),
        .FLUSH_DONE           (flush_done),
        .REG_TSARB_STARVE_CNT (starve)
    );

    task automatic chk(input string tag, input logic [75:0] obs,
                       input logic [75:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int  pops;
        bit  done_seen;
        bit  dec;
        bit  bad_flush;
        logic [1:0] eg;

        rst = 1'b1; req = '0; rd = '0; words = '0; flush_req = 1'b0;
        tick(); tick();
        #1;
        chk("rst_gnt", 76'(gnt), 76'd0);
        chk("rst_rsp_valid", 76'(rsp_valid), 76'd0);
        chk("rst_pop", 76'(pop), 76'd0);
        chk("rst_done", 76'(flush_done), 76'd0);
        chk("rst_starve", 76'(starve), 76'd0);
        chk("rst_ts", rsp_ts, 76'd0);
        rst = 1'b0;
        tick();

        // Single request, request dropped after grant
        req = 2'b01; words = 5'd3; rd = 76'hA5;
        tick(); #1;
        chk("single_pop", 76'(pop), 76'd1);
        chk("single_gnt", 76'(gnt), 76'h1);
        req = 2'b00;
        tick(); #1;
        chk("single_wait_pop", 76'(pop), 76'd0);
        chk("single_wait_rsp", 76'(rsp_valid), 76'd0);
        tick(); #1;
        chk("single_rsp_valid", 76'(rsp_valid), 76'h1);
        chk("single_rsp_ts", rsp_ts, 76'hA5);
        rd = 76'h77;
        tick(); #1;
        chk("single_rsp_drop", 76'(rsp_valid), 76'd0);
        chk("single_ts_hold", rsp_ts, 76'hA5);

        // Reset while a response is in flight
        req = 2'b01; rd = 76'hBB;
        tick(); #1;
        chk("rstw_gnt", 76'(gnt), 76'h1);
        req = 2'b00;
        tick();
        rst = 1'b1; #1;
        chk("rstw_rsp_valid", 76'(rsp_valid), 76'd0);
        chk("rstw_ts", rsp_ts, 76'd0);
        chk("rstw_pop", 76'(pop), 76'd0);
        chk("rstw_gnt0", 76'(gnt), 76'd0);
        tick();
        rst = 1'b0;
        tick(); #1;
        chk("rstw_no_rsp", 76'(rsp_valid), 76'd0);
        chk("rstw_idle_pop", 76'(pop), 76'd0);

        // Contention: grants alternate, 3 cycles apart
        req = 2'b11; words = 5'd8; rd = 76'h11;
        for (int k = 1; k <= 12; k++) begin
            tick(); #1;
            eg = (k % 3 == 1) ? ((((k - 1) / 3) % 2 == 1) ? 2'b10 : 2'b01)
                              : 2'b00;
            chk($sformatf("cont_gnt_%0d", k), 76'(gnt), 76'(eg));
            chk($sformatf("cont_pop_%0d", k), 76'(pop), 76'(eg != 2'b00));
            if (k % 3 == 0)
                chk($sformatf("cont_rsp_%0d", k), 76'(rsp_valid),
                    76'((((k - 3) / 3) % 2 == 1) ? 2'b10 : 2'b01));
        end
        req = 2'b00;
        tick();

        // Empty FIFO: request stays pending and starvation counts
        req = 2'b01; words = 5'd0;
        bad_flush = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(); #1;
            if (pop || gnt != 2'b00) bad_flush = 1'b1;
        end
        chk("empty_no_pop", 76'(bad_flush), 76'd0);
        chk("empty_starve", 76'(starve), 76'd10);
        words = 5'd1;
        tick(); #1;
        chk("empty_gnt", 76'(gnt), 76'h1);
        chk("empty_starve_hold", 76'(starve), 76'd10);
        req = 2'b00;
        tick(); tick(); #1;
        chk("empty_rsp", 76'(rsp_valid), 76'h1);

        // Flush with a request pending: 4 pops, done, then grant
        req = 2'b10; words = 5'd4; flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        pops = 0; done_seen = 1'b0; dec = 1'b0; bad_flush = 1'b0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            if (dec) begin
                words = words - 5'd1;
                dec = 1'b0;
            end
            #1;
            if (gnt != 2'b00 || rsp_valid != 2'b00) bad_flush = 1'b1;
            if (pop) begin
                pops++;
                dec = 1'b1;
            end
            if (flush_done) done_seen = 1'b1;
            else tick();
        end
        chk("flush_done_seen", 76'(done_seen), 76'd1);
        chk("flush_pops", 76'(pops), 76'd4);
        chk("flush_no_gnt", 76'(bad_flush), 76'd0);
        tick(); #1;
        chk("flush_done_pulse", 76'(flush_done), 76'd0);
        words = 5'd2;
        tick(); #1;
        chk("flush_after_gnt", 76'(gnt), 76'h2);
        req = 2'b00;
        tick(); tick(); #1;
        chk("flush_after_rsp", 76'(rsp_valid), 76'h2);

        // Drive starvation near saturation
        req = 2'b01; words = 5'd0;
        repeat (65520) tick();
        #1;
        chk("sat_preload", 76'(starve), 76'hFFFA);

        // Flush requested while a pop is in flight
        words = 5'd1; rd = 76'hC0FFEE;
        tick(); #1;
        chk("fw_gnt", 76'(gnt), 76'h1);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0; #1;
        chk("fw_wait_pop", 76'(pop), 76'd0);
        chk("fw_wait_done", 76'(flush_done), 76'd0);
        tick(); #1;
        chk("fw_rsp", 76'(rsp_valid), 76'h1);
        chk("fw_rsp_ts", rsp_ts, 76'hC0FFEE);
        chk("fw_rsp_done", 76'(flush_done), 76'd0);
        words = 5'd0;
        tick(); #1;
        chk("fw_done", 76'(flush_done), 76'd1);
        chk("fw_done_gnt", 76'(gnt), 76'd0);
        chk("fw_starve", 76'(starve), 76'hFFFB);
        tick();
        repeat (10) tick();
        #1;
        chk("sat_ffff", 76'(starve), 76'hFFFF);
        tick(); tick(); #1;
        chk("sat_hold", 76'(starve), 76'hFFFF);
        chk("sat_no_pop", 76'(pop), 76'd0);
        req = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
